// File: rtl/quant_ctrl.sv
// JPEG quantization sequencer: walks the 8x8 raster index, divides each signed
// coefficient by its table entry (restoring divider, round half away from zero).
module quant_ctrl #(
  parameter int COEF_W = 12,
  parameter int Q_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [COEF_W-1:0] in_coef,
  input  logic                     in_first,
  output logic [5:0]               rom_addr,
  input  logic [Q_W-1:0]           rom_q,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [COEF_W-1:0] out_coef,
  output logic [5:0]               out_idx,
  output logic                     out_last,
  output logic                     busy
);

  localparam int CNT_W = $clog2(COEF_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COEF_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    OUT  = 2'd2
  } state_e;

  state_e              state_q;
  logic [5:0]          idx_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                sign_q;
  logic [Q_W-1:0]      div_q;
  logic [COEF_W-1:0]   dvd_q;
  logic [Q_W-1:0]      rem_q;
  logic                in_ready_q;
  logic                busy_q;
  logic                out_valid_q;
  logic [COEF_W-1:0]   out_coef_q;
  logic [5:0]          out_idx_q;
  logic                out_last_q;

  logic [COEF_W-1:0]   coef_u_d;
  logic [COEF_W-1:0]   mag_d;
  logic [COEF_W-1:0]   dividend_d;
  logic [Q_W:0]        trial_d;
  logic [Q_W-1:0]      diff_d;
  logic                ge_d;
  logic [Q_W-1:0]      rem_d;
  logic [COEF_W-1:0]   quot_d;
  logic [COEF_W-1:0]   result_d;

  // The dividend register doubles as the quotient shift register: MSB out, quotient bit in.
  always_comb begin
    coef_u_d   = in_coef;
    mag_d      = coef_u_d[COEF_W-1] ? (~coef_u_d + COEF_W'(1)) : coef_u_d;
    dividend_d = mag_d + {{(COEF_W-Q_W+1){1'b0}}, rom_q[Q_W-1:1]};
    trial_d    = {rem_q, dvd_q[COEF_W-1]};
    ge_d       = (trial_d >= {1'b0, div_q});
    diff_d     = trial_d[Q_W-1:0] - div_q;
    rem_d      = ge_d ? diff_d : trial_d[Q_W-1:0];
    quot_d     = {dvd_q[COEF_W-2:0], ge_d};
    if (div_q == {Q_W{1'b0}}) begin
      result_d = {COEF_W{1'b0}};
    end else if (sign_q) begin
      result_d = ~quot_d + COEF_W'(1);
    end else begin
      result_d = quot_d;
    end
  end

  always_comb begin
    if ((state_q == IDLE) && in_first) begin
      rom_addr = 6'd0;
    end else begin
      rom_addr = idx_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 6'd0;
      cnt_q       <= {CNT_W{1'b0}};
      sign_q      <= 1'b0;
      div_q       <= {Q_W{1'b0}};
      dvd_q       <= {COEF_W{1'b0}};
      rem_q       <= {Q_W{1'b0}};
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_coef_q  <= {COEF_W{1'b0}};
      out_idx_q   <= 6'd0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q     <= in_coef[COEF_W-1];
            div_q      <= rom_q;
            dvd_q      <= dividend_d;
            rem_q      <= {Q_W{1'b0}};
            cnt_q      <= {CNT_W{1'b0}};
            idx_q      <= in_first ? 6'd0 : idx_q;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= DIV;
          end
        end
        DIV: begin
          rem_q <= rem_d;
          dvd_q <= quot_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            out_valid_q <= 1'b1;
            out_coef_q  <= result_d;
            out_idx_q   <= idx_q;
            out_last_q  <= (idx_q == 6'd63);
            state_q     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            idx_q       <= idx_q + 6'd1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_coef  = out_coef_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_quant_ctrl.sv
// Self-checking bench for quant_ctrl: directed cases plus random coefficients
// compared against an arithmetic quantization model and a raster index tracker.
module tb_quant_ctrl;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [11:0] in_coef = 12'sd0;
  logic               in_first = 1'b0;
  logic [5:0]         rom_addr;
  logic [7:0]         rom_q;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [11:0] out_coef;
  logic [5:0]         out_idx;
  logic               out_last;
  logic               busy;

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int model_idx = 0;

  int qtab [64] = '{16, 11, 10, 16, 24, 40, 51, 61,
                    12, 12, 14, 19, 26, 58, 60, 55,
                    14, 13, 16, 24, 40, 57, 69, 56,
                    14, 17, 22, 29, 51, 87, 80, 62,
                    18, 22, 37, 56, 68, 109, 103, 77,
                    24, 35, 55, 64, 81, 104, 113, 92,
                    49, 64, 78, 87, 103, 121, 120, 101,
                    72, 92, 95, 98, 112, 100, 103, 99};

  assign rom_q = 8'(qtab[rom_addr]);

  quant_ctrl #(.COEF_W(12), .Q_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_coef(in_coef), .in_first(in_first),
    .rom_addr(rom_addr), .rom_q(rom_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_coef(out_coef),
    .out_idx(out_idx), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int ref_quant(input int c, input int q);
    int m;
    if (q == 0) return 0;
    m = (c < 0) ? -c : c;
    m = (m + q / 2) / q;
    return (c < 0) ? -m : m;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One coefficient through the block; hold = cycles of out_ready=0 once in OUT.
  task automatic send(input int coef, input bit first, input int hold, input bit busy_first);
    int eidx;
    int exp;
    int lat;
    lat = 0;
    while (!in_ready && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    check("in_ready_wait", int'(in_ready), 1);
    eidx = first ? 0 : model_idx;
    in_valid  = 1'b1;
    in_coef   = coef[11:0];
    in_first  = first;
    out_ready = (hold == 0);
    #1;
    check("rom_addr", int'(rom_addr), eidx);
    exp = ref_quant(coef, qtab[eidx]);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_first = busy_first;
    in_coef  = 12'($urandom);
    check("busy_after_accept", int'({in_ready, busy}), 1);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    in_first = 1'b0;
    check("latency", lat, 12);
    check("out_coef", int'(out_coef), exp);
    check("out_idx", int'(out_idx), eidx);
    check("out_last", int'(out_last), int'(eidx == 63));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid_ready", int'({out_valid, in_ready}), 2);
      check("hold_coef", int'(out_coef), exp);
      check("hold_idx", int'(out_idx), eidx);
      check("hold_last", int'(out_last), int'(eidx == 63));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("transfer", int'({out_valid, in_ready, busy}), 2);
    out_ready = 1'b0;
    model_idx = (eidx + 1) % 64;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready_busy"}, int'({in_ready, busy}), 2);
    check({tag, "_valid"}, int'(out_valid), 0);
    check({tag, "_coef"}, int'(out_coef), 0);
    check({tag, "_idx_last"}, int'({out_idx, out_last}), 0);
    check({tag, "_rom_addr"}, int'(rom_addr), 0);
  endtask

  initial begin
    int saved;
    int seen;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    model_idx = 0;

    send(100, 1'b1, 0, 1'b0);
    send(-100, 1'b1, 0, 1'b0);
    send(8, 1'b1, 0, 1'b0);
    send(7, 1'b1, 0, 1'b0);
    send(0, 1'b1, 0, 1'b0);

    send(5, 1'b0, 0, 1'b0);
    send(-2048, 1'b0, 0, 1'b0);
    while (model_idx != 37) send(int'($urandom_range(4095)) - 2048, 1'b0, 0, 1'b0);
    send(2047, 1'b0, 0, 1'b0);
    send(2047, 1'b1, 0, 1'b0);

    send(-777, 1'b0, 5, 1'b0);

    send(4 * qtab[0], 1'b1, 0, 1'b0);
    for (int i = 1; i < 64; i++) send(4 * qtab[i], 1'b0, 0, 1'b0);
    send(300, 1'b0, 0, 1'b0);

    for (int i = 0; i < 10; i++) send(int'($urandom_range(4095)) - 2048, 1'b0, 0, 1'b0);
    send(32, 1'b1, 0, 1'b0);
    send(-1500, 1'b0, 0, 1'b1);
    send(1234, 1'b0, 0, 1'b0);

    saved = qtab[0];
    qtab[0] = 0;
    send(500, 1'b1, 0, 1'b0);
    qtab[0] = saved;

    for (int i = 0; i < 100; i++)
      send(int'($urandom_range(4095)) - 2048, ($urandom_range(7) == 0),
           int'($urandom_range(3)), 1'($urandom_range(1)));

    send(900, 1'b0, 0, 1'b0);
    in_valid = 1'b1;
    in_coef  = 12'sd700;
    in_first = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #2;
    check_reset_values("async_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    model_idx = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("no_emit_after_reset", seen, 0);
    send(-400, 1'b0, 0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/quant_ctrl.md
# quant_ctrl

Sequencer for the JPEG quantization stage. It accepts signed DCT coefficients for an 8x8 block in raster (row-major) order and tracks the coefficient index, which it drives onto the quantization-table ROM address. Each coefficient is divided by its table entry with a multi-cycle restoring divider, rounding half away from zero. Results go downstream with a valid/ready handshake, carrying index and end-of-block tags. It sits between the 2-D DCT output and the zigzag/entropy stage.

## Interface
- COEF_W, 12, signed coefficient width in and out; also the divider iteration count
- Q_W, 8, quantizer table entry width (unsigned)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  coefficient available
- in_ready  out  1  block can accept; high only in IDLE
- in_coef  in  COEF_W  signed two's-complement DCT coefficient
- in_first  in  1  qualifies in_coef as index 0 of a new block (resync)
- rom_addr  out  6  table address, = index of current coefficient
- rom_q  in  Q_W  table entry for rom_addr (combinational ROM, same cycle)
- out_valid  out  1  quantized result available
- out_ready  in  1  downstream accepts
- out_coef  out  COEF_W  signed quantized coefficient
- out_idx  out  6  raster index of out_coef
- out_last  out  1  out_idx == 63
- busy  out  1  state != IDLE

## Operation
- States: IDLE, DIV, OUT.
- IDLE: in_ready=1. On in_valid:
  - Capture sign s = in_coef[MSB] and divisor d = rom_q.
  - Dividend = |in_coef| + (rom_q >> 1), unsigned, COEF_W bits (no overflow: 2^(COEF_W-1)+127 fits for COEF_W>=9).
  - Go to DIV with iteration counter = 0.
- Index: rom_addr = in_first ? 0 : idx in IDLE, so rom_q is correct at the accepting edge. On accept with in_first=1, idx loads 0 before use.
- DIV: one restoring step per cycle, MSB first. Partial remainder is Q_W+1 bits. Run COEF_W cycles, then go to OUT.
- OUT: out_valid=1, and out_coef/out_idx/out_last are held stable.
  - out_coef = s ? -quot : quot, where quot = floor(dividend/d).
  - If d==0, out_coef=0.
- On out_valid & out_ready: idx <= idx+1 (63 wraps to 0), state -> IDLE.
- in_first while busy is ignored; it is sampled only at accept.
- No other error handling. Magnitude of -2^(COEF_W-1) is representable in the unsigned dividend.

## Timing
- Reset (async): state=IDLE, idx=0, in_ready=1 (follows state), out_valid=0, out_coef=0, out_idx=0, out_last=0, busy=0. rom_addr=0.
- Reset mid-division or mid-OUT: the in-flight coefficient is discarded and nothing is emitted.
- Latency: accept edge N -> out_valid high after edge N+COEF_W (12 cycles by default).
- Throughput: with out_ready held high, one coefficient per COEF_W+2 cycles (14), i.e. 896 cycles per block.
- Backpressure: in OUT with out_ready=0, all outputs are held indefinitely. in_ready stays 0.
- No combinational path from in_valid/out_ready to in_ready/out_valid. Only rom_addr is combinational, from in_first.
- Simultaneous in_first and idx==63 wrap: in_first wins, and the coefficient is tagged index 0.

## Test plan
- Reset then idx0 coefficients: 100 -> 6, -100 -> -6, 8 -> 1, 7 -> 0, 0 -> 0. Each out_valid arrives exactly 12 cycles after accept, with out_idx=0. Also assert reset values and rom_addr=0.
- Extremes:
  - -2048 at idx2 (q=10) -> -205.
  - 2047 at idx37 (q=109) -> 19.
  - 2047 at idx0 (q=16) -> 128.
- Full block: 64 coefficients, each = 4*q[i], in_first on the first. Require outputs 4 at idx 0..63 in order. out_last is high only at idx63; then idx wraps and the next accept uses rom_addr=0.
- Backpressure: hold out_ready=0 for 5 cycles in OUT. out_coef, out_idx and out_last stay stable, in_ready=0 throughout, and exactly one transfer occurs.
- Resync: after 10 coefficients, send in_first=1 with coef 32. Require out_idx=0 and out_coef=2. Separately, in_first asserted while busy has no effect.
- Async reset asserted in DIV cycle 6: out_valid never rises, and the next accepted coefficient is at idx0.
